protocol_frame_ctrl: RTL and testbench

PROTOCOL_FRAME_CTRL -- requirements
Module: tt_um_hoene_protocol_frame_ctrl

---
 rtl/protocol_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_protocol_frame_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/protocol_frame_ctrl.sv
// Pulse-width serial LED frame decoder: 32-bit words (30 data, use flag, even parity) delimited by low gaps.
// Optional line forwarding to the next node is enabled by defining SERIAL_CTRL_FORWARD_EN.
module protocol_frame_ctrl #(
    parameter int T_THRESH = 24,
    parameter int T_RESET  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output logic       shift_clk,
    output logic       shift_data,
    output logic       store,
    output logic       dout,
    output logic [5:0] bit_count,
    output logic [1:0] err
);

    localparam int LW = $clog2(T_RESET + 1);

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        RECEIVE  = 2'd1,
        FORWARD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic          din_m, din_s, din_q;
    logic [7:0]    high_cnt;
    logic [LW-1:0] low_cnt;
    logic          gap;
    logic          fall;
    logic          bit_val;
    logic          parity;
    logic          use_flag;
    logic          word_done;
    logic          in_recv;
    logic          last_bit;
    logic          word_ok;

    // din is asynchronous; din_q is one extra stage used only for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_q <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_q <= din_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt <= '0;
            low_cnt  <= '0;
            gap      <= 1'b0;
        end else begin
            if (din_s) begin
                high_cnt <= (high_cnt == 8'hFF) ? high_cnt : high_cnt + 8'd1;
                low_cnt  <= '0;
            end else begin
                high_cnt <= '0;
                if (low_cnt != LW'(T_RESET))
                    low_cnt <= low_cnt + 1'b1;
            end
            // Registered so the pulse coincides with low_cnt landing on T_RESET.
            gap <= !din_s && (low_cnt == LW'(T_RESET - 1));
        end
    end

    // high_cnt still holds the finished pulse width in the cycle the fall is seen.
    assign fall     = din_q && !din_s;
    assign bit_val  = (high_cnt >= 8'(T_THRESH));
    assign last_bit = (bit_count == 6'd31);
    assign word_ok  = word_done && !parity && use_flag;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= WAIT_GAP;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (gap)
            state_nxt = RECEIVE;
        else if (in_recv && fall && last_bit)
            state_nxt = FORWARD;
    end

    // FSM: outputs
    always_comb begin
        in_recv = (state == RECEIVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_clk  <= 1'b0;
            shift_data <= 1'b0;
            word_done  <= 1'b0;
            store      <= 1'b0;
            bit_count  <= '0;
            parity     <= 1'b0;
            use_flag   <= 1'b0;
        end else begin
            shift_clk  <= in_recv && fall;
            shift_data <= in_recv && fall && bit_val;
            word_done  <= in_recv && fall && last_bit;
            store      <= word_ok;
            if (gap) begin
                bit_count <= '0;
                parity    <= 1'b0;
                use_flag  <= 1'b0;
            end else if (in_recv && fall) begin
                bit_count <= bit_count + 6'd1;
                parity    <= parity ^ bit_val;
                if (bit_count == 6'd30)
                    use_flag <= bit_val;
            end
        end
    end

    // Errors are sticky; only a word that is actually stored clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 2'b00;
        end else if (word_ok) begin
            err <= 2'b00;
        end else begin
            if (word_done && parity)
                err[0] <= 1'b1;
            if (gap && in_recv && (bit_count != 6'd0))
                err[1] <= 1'b1;
        end
    end

`ifdef SERIAL_CTRL_FORWARD_EN
    assign dout = (state == FORWARD) && din_s;
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_protocol_frame_ctrl.sv
// Bench for protocol_frame_ctrl: table-driven frames, threshold boundary, reset mid-frame,
// and random frames checked against a word-level model of the frame rules.
module tb_protocol_frame_ctrl;

    localparam int T_THRESH = 24;
    localparam int T_RESET  = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       shift_clk;
    logic       shift_data;
    logic       store;
    logic       dout;
    logic [5:0] bit_count;
    logic [1:0] err;

    protocol_frame_ctrl #(.T_THRESH(T_THRESH), .T_RESET(T_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .din(din),
        .shift_clk(shift_clk), .shift_data(shift_data), .store(store),
        .dout(dout), .bit_count(bit_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        bit          tail_gap;
        int          exp_shifts;
        int          exp_stores;
        logic [1:0]  exp_err;
        int          exp_bc;
    } vec_t;

    vec_t vecs[6];

    int n_checks, n_pass;
    int shifts, stores, dout_cnt, bit_errs, store_lat, cyc, last_shift_cyc;

    // Frame-level reference state.
    bit          m_acc;
    int          m_bc;
    logic [1:0]  m_err;
    logic [31:0] m_word;
    int          m_stores, m_shifts, m_dout;
    logic [0:0]  exp_q[$];

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (shift_clk) begin
            shifts++;
            last_shift_cyc = cyc;
            if (exp_q.size() == 0)
                bit_errs++;
            else if (exp_q.pop_front() !== shift_data)
                bit_errs++;
        end
        if (store) begin
            stores++;
            store_lat = cyc - last_shift_cyc;
        end
        if (dout)
            dout_cnt++;
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        shifts = 0; stores = 0; dout_cnt = 0; bit_errs = 0; store_lat = -1;
        m_stores = 0; m_shifts = 0; m_dout = 0;
        exp_q.delete();
    endtask

    task automatic send_gap();
        if (m_acc && m_bc > 0 && m_bc < 32)
            m_err[1] = 1'b1;
        m_acc = 1'b1;
        m_bc = 0;
        m_word = '0;
        drive(1'b0, T_RESET + 10);
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        if (m_acc && m_bc < 32) begin
            exp_q.push_back(b);
            m_shifts++;
            m_word[m_bc] = b;
            m_bc++;
            if (m_bc == 32) begin
                if (^m_word)
                    m_err[0] = 1'b1;
                else if (m_word[30]) begin
                    m_stores++;
                    m_err = 2'b00;
                end
            end
        end else if (m_acc && m_bc == 32) begin
`ifdef SERIAL_CTRL_FORWARD_EN
            m_dout += hi;
`endif
        end
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    // mode 0: nominal widths, 1: exactly at/below threshold, 2: random widths
    task automatic send_word(input logic [63:0] w, input int n, input int mode);
        int hi, lo;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin hi = w[i] ? 40 : 10; lo = 30; end
                1: begin hi = w[i] ? T_THRESH : T_THRESH - 1; lo = 30; end
                default: begin
                    hi = w[i] ? int'($urandom_range(T_THRESH, 60)) : int'($urandom_range(1, T_THRESH - 1));
                    lo = int'($urandom_range(2, 40));
                end
            endcase
            send_bit(w[i], hi, lo);
        end
    endtask

    task automatic check_frame(input string tag, input int e_shifts, input int e_stores,
                               input logic [1:0] e_err, input int e_bc, input int e_dout);
        drive(1'b0, 20);
        check({tag, ".shifts"}, shifts, e_shifts);
        check({tag, ".stores"}, stores, e_stores);
        check({tag, ".err"}, int'(err), int'(e_err));
        check({tag, ".bit_count"}, int'(bit_count), e_bc);
        check({tag, ".bits"}, bit_errs, 0);
        check({tag, ".pending"}, exp_q.size(), 0);
        check({tag, ".dout"}, dout_cnt, e_dout);
        if (e_stores > 0)
            check({tag, ".store_lat"}, store_lat, 1);
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".shift_clk"}, int'(shift_clk), 0);
        check({tag, ".shift_data"}, int'(shift_data), 0);
        check({tag, ".store"}, int'(store), 0);
        check({tag, ".dout"}, int'(dout), 0);
        check({tag, ".bit_count"}, int'(bit_count), 0);
        check({tag, ".err"}, int'(err), 0);
    endtask

    initial begin
        logic [31:0] w;
        int n;
        n_checks = 0; n_pass = 0; cyc = 0; last_shift_cyc = 0;
        m_acc = 1'b0; m_bc = 0; m_err = 2'b00; m_word = '0;
        clear_mon();
        rst_n = 1'b0;
        din = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        vecs[0] = '{32'h40000001, 32, 1'b0, 32, 1, 2'b00, 32};
        vecs[1] = '{32'hC0000001, 32, 1'b0, 32, 0, 2'b01, 32};
        vecs[2] = '{32'h40000001, 32, 1'b0, 32, 1, 2'b00, 32};
        vecs[3] = '{32'h80000001, 32, 1'b0, 32, 0, 2'b00, 32};
        vecs[4] = '{32'h00000ABC, 12, 1'b1, 12, 0, 2'b10, 0};
        vecs[5] = '{32'h40000001, 32, 1'b0, 32, 1, 2'b00, 32};

        for (int i = 0; i < 6; i++) begin
            clear_mon();
            send_gap();
            send_word({32'h0, vecs[i].word}, vecs[i].nbits, 0);
            if (vecs[i].tail_gap)
                send_gap();
            check_frame($sformatf("vec%0d", i), vecs[i].exp_shifts, vecs[i].exp_stores,
                        vecs[i].exp_err, vecs[i].exp_bc, 0);
        end

        // Pulse widths exactly T_THRESH (one) and T_THRESH-1 (zero).
        clear_mon();
        send_gap();
        send_word({32'h0, 32'h4000FFFE}, 32, 1);
        check_frame("thresh", 32, 1, 2'b00, 32, 0);

        // Reset in the middle of a frame, with a sticky error pending.
        clear_mon();
        send_gap();
        send_word({32'h0, 32'hC0000001}, 32, 0);
        send_gap();
        send_word({32'h0, 32'h40000001}, 10, 0);
        rst_n = 1'b0;
        m_acc = 1'b0; m_bc = 0; m_err = 2'b00;
        drive(1'b0, 3);
        check_reset("midreset");
        rst_n = 1'b1;
        clear_mon();
        send_word({32'h0, 32'h40000001 >> 10}, 22, 0);
        check_frame("rst_tail", 0, 0, 2'b00, 0, 0);
        clear_mon();
        send_gap();
        send_word({32'h0, 32'h40000001}, 32, 0);
        check_frame("rst_recover", 32, 1, 2'b00, 32, 0);

        for (int r = 0; r < 6; r++) begin
            w = $urandom;
            w[31] = (^w[30:0]) ^ ($urandom_range(0, 3) == 0);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
            clear_mon();
            send_gap();
            send_word({32'h0, w}, n, 2);
            check_frame($sformatf("rnd%0d", r), m_shifts, m_stores, m_err, m_bc, m_dout);
        end

        // 64 bits after one gap: only the first word is decoded, the rest is forwardable.
        clear_mon();
        send_gap();
        send_word({32'($urandom), 32'h40000001}, 64, 2);
        check_frame("fwd", 32, 1, 2'b00, 32, m_dout);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
